// File: rtl/clause_queue.sv
// Per-engine clause FIFO with first-word-fall-through head and registered backpressure.
// Optional statistics outputs are enabled by defining CLAUSE_QUEUE_STATS_EN.
module clause_queue #(
  parameter int VARIABLE_LENGTH = 11,
  parameter int CLA_LENGTH      = 3,
  parameter int DEPTH           = 8,
  parameter int FULL_SLACK      = 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  grant_in,
  input  logic [CLA_LENGTH*VARIABLE_LENGTH-1:0] clause_in,
  input  logic                                  pop_in,
  input  logic                                  flush_in,
  output logic                                  full_out,
  output logic [CLA_LENGTH*VARIABLE_LENGTH-1:0] clause_out,
  output logic                                  valid_out,
  output logic [$clog2(DEPTH):0]                count_out,
`ifdef CLAUSE_QUEUE_STATS_EN
  output logic [15:0]                           push_cnt_out,
  output logic [15:0]                           drop_cnt_out,
  output logic [$clog2(DEPTH):0]                max_occ_out,
`endif
  output logic                                  overflow_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = CLA_LENGTH * VARIABLE_LENGTH;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          overflow;
  logic          pop_eff, push_eff, drop;

  assign pop_eff  = pop_in && (count != '0);
  assign push_eff = grant_in && ((count < CW'(DEPTH)) || pop_eff);
  assign drop     = grant_in && !flush_in && (count == CW'(DEPTH)) && !pop_eff;

  always_comb begin
    count_nxt = count;
    if (flush_in)
      count_nxt = '0;
    else if (push_eff && !pop_eff)
      count_nxt = count + CW'(1);
    else if (pop_eff && !push_eff)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count_nxt;
      if (flush_in) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_eff) wr_ptr <= wr_ptr + AW'(1);
        if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage is not reset; valid_out masks stale contents.
  always_ff @(posedge clock) begin
    if (!reset && !flush_in && push_eff)
      mem[wr_ptr] <= clause_in;
  end

  assign valid_out    = (count != '0);
  assign clause_out   = valid_out ? mem[rd_ptr] : '0;
  assign full_out     = (count >= CW'(DEPTH - FULL_SLACK));
  assign count_out    = count;
  assign overflow_out = overflow;

`ifdef CLAUSE_QUEUE_STATS_EN
  logic [15:0]   push_cnt, drop_cnt;
  logic [CW-1:0] max_occ;

  always_ff @(posedge clock) begin
    if (reset) begin
      push_cnt <= '0;
      drop_cnt <= '0;
      max_occ  <= '0;
    end else begin
      if (push_eff && !flush_in && push_cnt != '1) push_cnt <= push_cnt + 16'd1;
      if (drop && drop_cnt != '1)                  drop_cnt <= drop_cnt + 16'd1;
      if (count_nxt > max_occ)                     max_occ  <= count_nxt;
    end
  end

  assign push_cnt_out = push_cnt;
  assign drop_cnt_out = drop_cnt;
  assign max_occ_out  = max_occ;
`endif

endmodule
